// File: rtl/dnn_monitor_pkg.sv
// Shared types and width helpers for the DNN output-side accuracy monitor.
package dnn_monitor_pkg;

    typedef enum logic [1:0] {SYNC, COLLECT, EVAL} state_t;

    localparam int CNT_W   = 32;
    localparam int EPOCH_W = 16;

    function automatic int ems_w(input int width, input int n_out);
        return 2 * width + $clog2(n_out);
    endfunction

    // Number of fractional bits carried by ems.
    function automatic int frac2(input int frac_bits);
        return 2 * frac_bits;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/correct_window.sv
// Circular bit buffer holding the last `depth` correctness flags and their running sum.
module correct_window #(
    parameter int depth = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         bit_in,
    output logic [$clog2(depth+1)-1:0]   recent
);

    localparam int RW = $clog2(depth + 1);
    localparam int PW = (depth <= 1) ? 1 : $clog2(depth);

    logic [depth-1:0] win_bits;
    logic [PW-1:0]    ptr;

    // NOTE: the buffer is cleared on reset on purpose: `recent` is derived by
    // subtracting the evicted bit, so stale contents would corrupt the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_bits <= '0;
            ptr      <= '0;
            recent   <= '0;
        end else if (push) begin
            recent        <= recent - RW'(win_bits[ptr]) + RW'(bit_in);
            win_bits[ptr] <= bit_in;
            ptr           <= (ptr == PW'(depth - 1)) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/dnn_accuracy_monitor.sv
// Per-case scoreboard: collects ideal bits and squared deltas over a block cycle,
// then evaluates correctness, error sum, moving-window accuracy and epoch counts.
module dnn_accuracy_monitor
    import dnn_monitor_pkg::*;
#(
    parameter int width           = 16,
    parameter int frac_bits       = 12,
    parameter int n_out           = 16,
    parameter int n_cmp           = 10,
    parameter int cpc             = 18,
    parameter int checklast       = 1000,
    parameter int cases_per_epoch = 10000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(cpc)-1:0]            cycle_index,
    input  logic                              y_out,
    input  logic [width-1:0]                  delta,
    input  logic [n_out-1:0]                  a_out_alln,
    output logic                              case_done,
    output logic                              correct,
    output logic [$clog2(checklast+1)-1:0]    recent,
    output logic [CNT_W-1:0]                  total_correct,
    output logic [CNT_W-1:0]                  num_train,
    output logic [ems_w(width, n_out)-1:0]    ems,
    output logic [EPOCH_W-1:0]                epoch,
    output logic                              epoch_done
);

    localparam int CI_W  = $clog2(cpc);
    localparam int EMS_W = ems_w(width, n_out);
    localparam int CIE_W = cnt_w(cases_per_epoch);

    if (cpc - 2 != n_out || n_cmp > n_out || frac2(frac_bits) > 2 * width) begin : g_bad_cfg
        $error("dnn_accuracy_monitor: inconsistent parameters");
    end

    state_t                  state, state_nxt;
    logic                    eval;
    logic                    collecting;
    logic                    correct_new;
    logic [n_out-1:0]        y_reg;
    logic [EMS_W-1:0]        acc;
    logic [CIE_W-1:0]        case_in_epoch;
    logic signed [2*width-1:0] sq;

    assign sq         = $signed(delta) * $signed(delta);
    assign collecting = (state != SYNC) && (cycle_index >= CI_W'(2));

    // NOTE: every combinational output gets a default before the case
    // statement so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        eval      = 1'b0;
        case (state)
            SYNC:    if (cycle_index == '0) state_nxt = COLLECT;
            COLLECT: if (cycle_index == '0) begin
                         eval      = 1'b1;
                         state_nxt = EVAL;
                     end
            EVAL:    if (cycle_index == '0) eval = 1'b1;
                     else                    state_nxt = COLLECT;
            default: state_nxt = SYNC;
        endcase
    end

    assign case_done = (state == EVAL);

    always_comb begin
        correct_new = 1'b1;
        for (int i = 0; i < n_cmp; i++)
            if (a_out_alln[i] != y_reg[i]) correct_new = 1'b0;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= SYNC;
            y_reg         <= '0;
            acc           <= '0;
            ems           <= '0;
            correct       <= 1'b0;
            total_correct <= '0;
            num_train     <= '0;
            case_in_epoch <= '0;
            epoch         <= '0;
            epoch_done    <= 1'b0;
        end else begin
            state      <= state_nxt;
            epoch_done <= 1'b0;
            if (eval) begin
                acc           <= '0;
                ems           <= acc;
                correct       <= correct_new;
                total_correct <= total_correct + CNT_W'(correct_new);
                num_train     <= num_train + CNT_W'(1);
                if (case_in_epoch == CIE_W'(cases_per_epoch - 1)) begin
                    case_in_epoch <= '0;
                    epoch         <= epoch + EPOCH_W'(1);
                    epoch_done    <= 1'b1;
                end else begin
                    case_in_epoch <= case_in_epoch + CIE_W'(1);
                end
            end else if (collecting) begin
                acc <= acc + EMS_W'($unsigned(sq));
                for (int i = 0; i < n_out; i++)
                    if (int'(cycle_index) == i + 2) y_reg[i] <= y_out;
            end
        end
    end

    correct_window #(.depth(checklast)) u_window (
        .clk    (clk),
        .reset  (reset),
        .push   (eval),
        .bit_in (correct_new),
        .recent (recent)
    );

endmodule

// File: tb/tb_dnn_accuracy_monitor.sv
// Randomized self-checking bench for dnn_accuracy_monitor against a case-level reference model.
module tb_dnn_accuracy_monitor;

    localparam int CPC = 18;
    localparam int NO  = 16;
    localparam int NC  = 10;
    localparam int CL  = 4;
    localparam int CPE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cycle_index;
    logic        y_out;
    logic [15:0] delta;
    logic [15:0] a_out_alln;
    logic        case_done, correct, epoch_done;
    logic [2:0]  recent;
    logic [31:0] total_correct, num_train;
    logic [35:0] ems;
    logic [15:0] epoch;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per evaluated case.
    bit          win_q[$];
    int unsigned m_total, m_num;
    bit          m_correct;
    longint      m_ems;

    logic [15:0] cur_y, cur_a;
    logic [15:0] cur_d [16];

    dnn_accuracy_monitor #(
        .width(16), .frac_bits(12), .n_out(NO), .n_cmp(NC), .cpc(CPC),
        .checklast(CL), .cases_per_epoch(CPE)
    ) dut (
        .clk(clk), .reset(reset), .cycle_index(cycle_index), .y_out(y_out),
        .delta(delta), .a_out_alln(a_out_alln), .case_done(case_done),
        .correct(correct), .recent(recent), .total_correct(total_correct),
        .num_train(num_train), .ems(ems), .epoch(epoch), .epoch_done(epoch_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        win_q.delete();
        m_total = 0; m_num = 0; m_correct = 0; m_ems = 0;
    endtask

    function automatic int model_recent();
        int s = 0;
        foreach (win_q[i]) s += win_q[i];
        return s;
    endfunction

    task automatic model_eval();
        longint s;
        m_correct = (((cur_y ^ cur_a) & 16'h03FF) == 16'h0000);
        m_ems = 0;
        for (int k = 0; k < NO; k++) begin
            s = longint'($signed(cur_d[k]));
            m_ems += s * s;
        end
        win_q.push_back(m_correct);
        if (win_q.size() > CL) void'(win_q.pop_front());
        m_num++;
        m_total += m_correct;
    endtask

    // Drives one full block (ci = 1, 2..17, 0) and compares every result output.
    task automatic send_case(input string tag);
        bit quiet_bad = 0;
        a_out_alln = cur_a;
        cycle_index = 5'd1; y_out = 1'b0; delta = '0;
        step();
        if (case_done !== 1'b0) quiet_bad = 1;
        for (int k = 0; k < NO; k++) begin
            cycle_index = 5'(k + 2); y_out = cur_y[k]; delta = cur_d[k];
            step();
            if (case_done !== 1'b0) quiet_bad = 1;
        end
        cycle_index = 5'd0; y_out = 1'b0; delta = '0;
        step();
        model_eval();
        checks++;
        if (quiet_bad) begin
            errors++; $display("FAIL %s case_done_quiet: pulse seen during collect", tag);
        end
        checks++;
        if (case_done !== 1'b1) begin
            errors++; $display("FAIL %s case_done: got %b exp 1", tag, case_done);
        end
        checks++;
        if (correct !== m_correct) begin
            errors++; $display("FAIL %s correct: got %b exp %b", tag, correct, m_correct);
        end
        checks++;
        if (ems !== 36'(m_ems)) begin
            errors++; $display("FAIL %s ems: got %0h exp %0h", tag, ems, m_ems);
        end
        checks++;
        if (int'(recent) !== model_recent()) begin
            errors++; $display("FAIL %s recent: got %0d exp %0d", tag, recent, model_recent());
        end
        checks++;
        if (total_correct !== m_total || num_train !== m_num) begin
            errors++; $display("FAIL %s counts: got total=%0d num=%0d exp total=%0d num=%0d",
                               tag, total_correct, num_train, m_total, m_num);
        end
        checks++;
        if (int'(epoch) !== int'(m_num / CPE) || epoch_done !== (m_num % CPE == 0)) begin
            errors++; $display("FAIL %s epoch: got epoch=%0d done=%b exp epoch=%0d done=%b",
                               tag, epoch, epoch_done, m_num / CPE, (m_num % CPE == 0));
        end
    endtask

    task automatic gen_case(input int mode); // 0: random, 1: force correct, 2: force wrong
        cur_y = 16'($urandom);
        cur_a = cur_y;
        if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1))
            cur_a = cur_y ^ (16'($urandom) & 16'hFC00);
        else
            cur_a[$urandom_range(0, NC - 1)] ^= 1'b1;
        foreach (cur_d[k]) cur_d[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
    endtask

    task automatic do_reset();
        reset = 1'b0; cycle_index = 5'd5; y_out = 1'b0; delta = '0; a_out_alln = '0;
        step(); step();
        reset = 1'b1; cycle_index = 5'd0;
        step();
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0; cycle_index = 5'd0; y_out = 1'b1; delta = 16'h7FFF; a_out_alln = 16'hFFFF;
        step(); step(); step();
        checks++;
        if ({case_done, correct, recent, total_correct, num_train, ems, epoch, epoch_done} !== '0) begin
            errors++; $display("FAIL reset_values: got nonzero outputs cd=%b c=%b r=%0d t=%0d n=%0d ems=%0h e=%0d ed=%b",
                               case_done, correct, recent, total_correct, num_train, ems, epoch, epoch_done);
        end
        reset = 1'b1; cycle_index = 5'd0;
        step();
        model_reset();
    endtask

    task automatic test_perfect();
        cur_y = 16'h0008; cur_a = 16'h0008;
        foreach (cur_d[k]) cur_d[k] = '0;
        send_case("perfect");
        checks++;
        if (correct !== 1'b1 || ems !== 36'd0 || recent !== 3'd1 || num_train !== 32'd1) begin
            errors++; $display("FAIL perfect_const: got c=%b ems=%0h r=%0d n=%0d exp 1 0 1 1",
                               correct, ems, recent, num_train);
        end
    endtask

    task automatic test_mismatch();
        cur_a = 16'h0010;
        send_case("mismatch_cmp");
        checks++;
        if (correct !== 1'b0) begin
            errors++; $display("FAIL mismatch_cmp_const: got %b exp 0", correct);
        end
        cur_a = 16'h1008;
        send_case("mismatch_ignored");
        checks++;
        if (correct !== 1'b1) begin
            errors++; $display("FAIL mismatch_ignored_const: got %b exp 1", correct);
        end
    endtask

    task automatic test_error_sum();
        cur_y = 16'h0008; cur_a = 16'h0008;
        foreach (cur_d[k]) cur_d[k] = 16'h0800;
        send_case("error_sum");
        checks++;
        if (ems !== (36'd4 << 24)) begin
            errors++; $display("FAIL error_sum_const: got %0h exp %0h", ems, 36'd4 << 24);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            gen_case(0);
            send_case($sformatf("random%0d", i));
        end
    endtask

    task automatic test_reset_mid_collect();
        bit early = 0;
        gen_case(0);
        a_out_alln = cur_a;
        cycle_index = 5'd1; step();
        for (int k = 2; k <= 7; k++) begin
            cycle_index = 5'(k); y_out = cur_y[k-2]; delta = cur_d[k-2];
            if (k == 7) reset = 1'b0;
            step();
        end
        checks++;
        if ({case_done, correct, recent, total_correct, num_train, ems, epoch, epoch_done} !== '0) begin
            errors++; $display("FAIL reset_mid_collect: got nonzero outputs r=%0d t=%0d n=%0d ems=%0h e=%0d",
                               recent, total_correct, num_train, ems, epoch);
        end
        reset = 1'b1;
        model_reset();
        for (int k = 8; k < CPC; k++) begin
            cycle_index = 5'(k); y_out = cur_y[k-2]; delta = cur_d[k-2];
            step();
            if (case_done !== 1'b0) early = 1;
        end
        cycle_index = 5'd0;
        step();
        if (case_done !== 1'b0) early = 1;
        checks++;
        if (early) begin
            errors++; $display("FAIL reset_first_pulse: case_done before second cycle_index==0");
        end
        gen_case(0);
        send_case("after_reset");
    endtask

    task automatic test_window();
        bit          seq [6] = '{1, 1, 1, 1, 0, 0};
        logic [2:0]  exp_r [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            gen_case(seq[i] ? 1 : 2);
            send_case($sformatf("window%0d", i));
            checks++;
            if (recent !== exp_r[i]) begin
                errors++; $display("FAIL window_const%0d: got %0d exp %0d", i, recent, exp_r[i]);
            end
        end
    endtask

    task automatic test_epoch();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            gen_case(0);
            send_case($sformatf("epoch%0d", i));
            checks++;
            if (epoch_done !== (i == 3 || i == 6)) begin
                errors++; $display("FAIL epoch_done_const%0d: got %b exp %b", i, epoch_done, (i == 3 || i == 6));
            end
        end
        checks++;
        if (epoch !== 16'd2) begin
            errors++; $display("FAIL epoch_count_const: got %0d exp 2", epoch);
        end
    endtask

    initial begin
        test_reset();
        test_perfect();
        test_mismatch();
        test_error_sum();
        test_random();
        test_reset_mid_collect();
        test_window();
        test_epoch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnn_accuracy_monitor.md
# dnn_accuracy_monitor

Synthesizable output-side scoreboard for the DNN training pipeline. Watches the serialized ideal-output stream (`y_out`, one neuron per clock) and the output-layer `delta`, together with the thresholded output vector `a_out_alln` and the shared `cycle_index` from `cycle_block_counter`. Once per block cycle it produces a per-case `correct` flag, a moving-window accuracy count, a running total, a squared-error sum and epoch bookkeeping. Accuracy tracking therefore runs on silicon rather than only in simulation.

## Interface
Parameters:
- `width`, 16, fixed-point word width of `delta`
- `frac_bits`, 12, fractional bits of `delta`
- `n_out`, 16, output neurons per case (`n[L-1]`)
- `n_cmp`, 10, neurons `0..n_cmp-1` that take part in the correctness compare; the rest are ignored
- `cpc`, 18, clocks per block cycle; `cpc-2` must equal `n_out`
- `checklast`, 1000, moving-window depth in cases
- `cases_per_epoch`, 10000, cases per epoch

Ports:
- `clk`, in, 1, clock; all logic is on the rising edge
- `reset`, in, 1, synchronous, active-low
- `cycle_index`, in, `$clog2(cpc)`, position within the block cycle
- `y_out`, in, 1, ideal output bit for neuron `cycle_index-2`
- `delta`, in, `width`, signed two's-complement delta for neuron `cycle_index-2`
- `a_out_alln`, in, `n_out`, thresholded actual outputs of all neurons
- `case_done`, out, 1, one-cycle pulse; all result outputs are updated while it is high
- `correct`, out, 1, last case fully correct
- `recent`, out, `$clog2(checklast+1)`, number of correct cases among the last `checklast`
- `total_correct`, out, 32, cumulative correct cases; wraps modulo 2^32
- `num_train`, out, 32, cases evaluated; wraps modulo 2^32
- `ems`, out, `2*width+$clog2(n_out)`, unsigned sum of `delta^2` over the case; `2*frac_bits` fractional bits
- `epoch`, out, 16, completed-epoch count
- `epoch_done`, out, 1, pulse coincident with the `case_done` that closes an epoch

## Operation
- **States:**
  - `SYNC`, entered on reset. The block waits for `cycle_index==0`, then goes to `COLLECT`. This discards any partial block seen after reset.
  - `COLLECT`, for `cycle_index` from 2 to `cpc-1`:
    - store `y_out` into `y_reg[cycle_index-2]`
    - add `delta*delta` (signed multiply, full `2*width` result) into `acc`
    - `cycle_index` values 0 and 1 are ignored
  - `EVAL`, taken on the edge where `cycle_index==0` after a full collect. On that edge the block:
    - sets `correct_r` to 1 when `a_out_alln[i]==y_reg[i]` for every `i<n_cmp`
    - loads `ems` from `acc`, then clears `acc`
    - updates `recent`, `total_correct`, `num_train` and the epoch counters
    - asserts `case_done` for the next cycle, then returns to `COLLECT`
- **Moving window:**
  - The window is a circular bit buffer of `checklast` entries with a write pointer that wraps from `checklast-1` to 0.
  - Each evaluation computes `recent <= recent - buf[ptr] + correct_new`, writes `buf[ptr] <= correct_new`, then advances `ptr`.
  - Reset clears the buffer, so during warm-up `recent` equals the number of correct cases so far.
- **Epoch:**
  - `case_in_epoch` counts evaluations.
  - On reaching `cases_per_epoch-1` and evaluating, the block wraps it to 0, increments `epoch` and pulses `epoch_done`.
- **`cycle_index` jump:** a non-monotonic jump of `cycle_index` in `COLLECT` (for example a re-sync) is not checked. The evaluation still fires at the next `cycle_index==0`.
- **Reset priority:** reset overrides everything, including mid-collect. All outputs, `acc`, `y_reg`, the window buffer and `ptr` return to 0, and the state returns to `SYNC`.

## Timing
- **Reset values:** every output is 0.
- **Latency:** results are registered on the `cycle_index==0` edge and visible while `cycle_index==1`, i.e. one clock after the last neuron's `y_out` and `delta` are captured.
- **`case_done`:** high for exactly one clock per block cycle, so there are `cpc-1` low cycles between pulses.
- **First pulse:** the first `case_done` after reset deasserts comes no earlier than the second `cycle_index==0` seen.
- **Simultaneous events:**
  - The window wrap, the epoch wrap and the first-case evaluation may all occur on the same edge, and each applies independently.
  - When `epoch_done` fires, `case_done` fires too.

## Structure
- **`dnn_monitor_pkg`** holds:
  - the state enum `{SYNC, COLLECT, EVAL}`
  - the counter widths
  - `EMS_W = 2*width+$clog2(n_out)`
  - the fixed-point helper constant `FRAC2 = 2*frac_bits`
- **`correct_window`** is the one natural sub-module: the circular bit buffer, the pointer and the `recent` update. Its ports are `clk`, `reset`, `push`, `bit_in` and `recent`.

## Test plan
Scenarios use `cpc=18`, `n_out=16`, `checklast=4` and `cases_per_epoch=3`.

1. **Reset mid-collect:** apply reset at `cycle_index==7` → all outputs 0. No `case_done` until the second `cycle_index==0` after release.
2. **Perfect case:** `y_out` one-hot on neuron 3, `a_out_alln=16'h0008`, all `delta=0` → `correct=1`, `ems=0`, `recent=1`, `num_train=1`.
3. **Mismatch on a compared neuron:** `a_out_alln=16'h0010` for the same ideal → `correct=0`. A mismatch only on neuron 12 (outside `n_cmp`) → `correct=1`.
4. **Error sum:** every `delta=16'h0800` (0.5) → `ems = 16*0.25 = 4.0`, i.e. raw value `4<<24`.
5. **Window wrap:** correct sequence 1,1,1,1,0,0 → `recent` reads 1,2,3,4,3,2.
6. **Epoch:** 7 cases → `epoch_done` pulses on cases 3 and 6, and `epoch=2` after case 7.
